// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - byte/half/word load-store front-end for a word-wide data memory
module mem_access_unit #(
    parameter int ADDR_W = 5
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic              ReqWrite,
    input  logic [1:0]        ReqSize,
    input  logic              ReqSigned,
    input  logic [ADDR_W+1:0] ReqAddr,
    input  logic [31:0]       ReqWData,
    output logic              RespValid,
    input  logic              RespReady,
    output logic [31:0]       RespRData,
    output logic              RespErr,
    output logic              MemWrEn,
    output logic [ADDR_W-1:0] MemAdr,
    output logic [31:0]       MemDataIn,
    input  logic [31:0]       MemDataOut
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_t;

    state_t              state_q, state_d;
    logic                write_q, write_d;
    logic [1:0]          size_q, size_d;
    logic                signed_q, signed_d;
    logic [ADDR_W+1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         old_q, old_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q, err_d;

    logic                req_err;
    logic [7:0]          ld_byte;
    logic [15:0]         ld_half;
    logic [31:0]         ld_val;
    logic [31:0]         merged;

    assign req_err = (ReqSize == 2'b11)
                   | ((ReqSize == 2'b01) & ReqAddr[0])
                   | ((ReqSize == 2'b10) & (|ReqAddr[1:0]));

    // Lane extraction works straight off the combinational memory read in READ.
    always_comb begin
        case (addr_q[1:0])
            2'd0:    ld_byte = MemDataOut[7:0];
            2'd1:    ld_byte = MemDataOut[15:8];
            2'd2:    ld_byte = MemDataOut[23:16];
            default: ld_byte = MemDataOut[31:24];
        endcase
        ld_half = addr_q[1] ? MemDataOut[31:16] : MemDataOut[15:0];
        case (size_q)
            2'b00:   ld_val = {{24{signed_q & ld_byte[7]}}, ld_byte};
            2'b01:   ld_val = {{16{signed_q & ld_half[15]}}, ld_half};
            default: ld_val = MemDataOut;
        endcase
    end

    always_comb begin
        merged = old_q;
        case (size_q)
            2'b00:   merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            2'b01: begin
                if (addr_q[1]) merged[31:16] = wdata_q[15:0];
                else           merged[15:0]  = wdata_q[15:0];
            end
            default: merged = wdata_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        size_d   = size_q;
        signed_d = signed_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        old_d    = old_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (ReqValid) begin
                    write_d  = ReqWrite;
                    size_d   = ReqSize;
                    signed_d = ReqSigned;
                    addr_d   = ReqAddr;
                    wdata_d  = ReqWData;
                    rdata_d  = 32'd0;
                    err_d    = req_err;
                    if (req_err)
                        state_d = S_RESP;
                    else if (ReqWrite && ReqSize == 2'b10)
                        state_d = S_WRITE;
                    else
                        state_d = S_READ;
                end
            end
            S_READ: begin
                old_d = MemDataOut;
                if (write_q) begin
                    state_d = S_WRITE;
                end else begin
                    rdata_d = ld_val;
                    state_d = S_RESP;
                end
            end
            S_WRITE: state_d = S_RESP;
            S_RESP: begin
                if (RespReady) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q  <= S_IDLE;
            write_q  <= 1'b0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= 32'd0;
            old_q    <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            old_q    <= old_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Memory pins depend only on registers so they settle well before the negedge write.
    assign ReqReady  = (state_q == S_IDLE);
    assign RespValid = (state_q == S_RESP);
    assign RespRData = rdata_q;
    assign RespErr   = err_q;
    assign MemWrEn   = (state_q == S_WRITE);
    assign MemAdr    = addr_q[ADDR_W+1:2];
    assign MemDataIn = (state_q == S_WRITE) ? merged : 32'd0;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit with a word-array reference model
module tb_mem_access_unit;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        ReqValid, ReqReady, ReqWrite, ReqSigned;
    logic [1:0]  ReqSize;
    logic [6:0]  ReqAddr;
    logic [31:0] ReqWData;
    logic        RespValid, RespReady, RespErr;
    logic [31:0] RespRData;
    logic        MemWrEn;
    logic [4:0]  MemAdr;
    logic [31:0] MemDataIn, MemDataOut;

    mem_access_unit #(.ADDR_W(5)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
        .ReqSize(ReqSize), .ReqSigned(ReqSigned), .ReqAddr(ReqAddr), .ReqWData(ReqWData),
        .RespValid(RespValid), .RespReady(RespReady), .RespRData(RespRData), .RespErr(RespErr),
        .MemWrEn(MemWrEn), .MemAdr(MemAdr), .MemDataIn(MemDataIn), .MemDataOut(MemDataOut)
    );

    always #5 Clk = ~Clk;

    // Memory device: combinational read, write on negedge.
    logic [31:0] mem [32];
    assign MemDataOut = mem[MemAdr];
    always @(negedge Clk) if (MemWrEn) mem[MemAdr] <= MemDataIn;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem [32];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          wr_cnt = 0;
    int          exp_wr = 0;
    logic        seen = 1'b0;
    logic [31:0] held;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic w, input logic [1:0] sz, input logic sg,
                                   input logic [6:0] a, input logic [31:0] wd);
        exp_t        e;
        int          nb, sh, idx;
        logic [63:0] mask;
        logic [31:0] v;
        nb   = 1 << sz;
        sh   = 8 * (int'(a) % 4);
        idx  = int'(a) / 4;
        mask = (64'd1 << (8 * nb)) - 64'd1;
        e.rdata = 32'd0;
        e.acc   = 0;
        e.err   = (sz == 2'b11) || (int'(a) % nb != 0);
        if (e.err) begin
            e.lat = 1;
        end else if (w) begin
            ref_mem[idx] = (ref_mem[idx] & ~(mask[31:0] << sh)) | ((wd & mask[31:0]) << sh);
            exp_wr++;
            e.lat = (sz == 2'b10) ? 2 : 3;
        end else begin
            v = (ref_mem[idx] >> sh) & mask[31:0];
            if (sg && sz != 2'b10 && v[8*nb-1]) v = v | ~mask[31:0];
            e.rdata = v;
            e.lat   = 2;
        end
        return e;
    endfunction

    // Monitor: pops one expectation per response and watches it while backpressured.
    always @(negedge Clk) begin
        exp_t e;
        if (!Rst_n) begin
            seen = 1'b0;
        end else begin
            if (MemWrEn) wr_cnt++;
            if (RespValid) begin
                chk("busy_req_ready", {31'd0, ReqReady}, 32'd0);
                if (!seen) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_resp actual=%h required=none", RespRData);
                    end else begin
                        e = exp_q.pop_front();
                        chk("resp_rdata", RespRData, e.rdata);
                        chk("resp_err", {31'd0, RespErr}, {31'd0, e.err});
                        chk("resp_latency", 32'(cyc - e.acc + 1), 32'(e.lat));
                    end
                    seen = 1'b1;
                    held = RespRData;
                end else begin
                    chk("resp_stable", RespRData, held);
                end
            end else begin
                seen = 1'b0;
            end
        end
    end

    task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [6:0] a, input logic [31:0] wd, input int hold);
        exp_t e;
        int   n;
        @(negedge Clk);
        n = 0;
        while (!ReqReady && n < 20) begin @(negedge Clk); n++; end
        if (!ReqReady) begin
            chk("req_ready_wait", {31'd0, ReqReady}, 32'd1);
            return;
        end
        RespReady = (hold == 0);
        ReqValid = 1'b1; ReqWrite = w; ReqSize = sz; ReqSigned = sg; ReqAddr = a; ReqWData = wd;
        @(posedge Clk); #1;
        ReqValid = 1'b0; ReqWrite = $urandom; ReqSize = 2'($urandom); ReqAddr = 7'($urandom);
        ReqWData = $urandom;
        e = model(w, sz, sg, a, wd);
        e.acc = cyc;
        exp_q.push_back(e);
        n = 0;
        do begin @(negedge Clk); n++; end while (!RespValid && n < 10);
        if (!RespValid) begin
            chk("resp_timeout", {31'd0, RespValid}, 32'd1);
            RespReady = 1'b1;
            return;
        end
        if (hold > 0) begin
            repeat (hold) @(negedge Clk);
            RespReady = 1'b1;
        end
        @(posedge Clk);
        @(negedge Clk);
        chk("ready_after_resp", {31'd0, ReqReady}, 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, {31'd0, ReqReady}, 32'd1);
        chk({tag, "_resp_valid"}, {31'd0, RespValid}, 32'd0);
        chk({tag, "_resp_err"}, {31'd0, RespErr}, 32'd0);
        chk({tag, "_resp_rdata"}, RespRData, 32'd0);
        chk({tag, "_mem_wren"}, {31'd0, MemWrEn}, 32'd0);
        chk({tag, "_mem_adr"}, {27'd0, MemAdr}, 32'd0);
        chk({tag, "_mem_datain"}, MemDataIn, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst_n = 1'b0; ReqValid = 1'b0; ReqWrite = 1'b0; ReqSize = 2'b00; ReqSigned = 1'b0;
        ReqAddr = 7'd0; ReqWData = 32'd0; RespReady = 1'b1;
        for (int i = 0; i < 32; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk_reset_outputs("reset");
        Rst_n = 1'b1;

        do_req(1'b1, 2'b10, 1'b0, 7'h08, 32'hDEADBEEF, 0);
        chk("word_store_mem", mem[2], 32'hDEADBEEF);
        do_req(1'b0, 2'b10, 1'b0, 7'h08, 32'd0, 0);

        @(negedge Clk);
        mem[1] = 32'h11223344; ref_mem[1] = 32'h11223344;
        do_req(1'b1, 2'b00, 1'b0, 7'h06, 32'h000000AB, 0);
        chk("byte_store_mem", mem[1], 32'h11AB3344);

        @(negedge Clk);
        mem[1] = 32'h80FF7F01; ref_mem[1] = 32'h80FF7F01;
        for (int s = 1; s >= 0; s--)
            for (int i = 4; i < 8; i++)
                do_req(1'b0, 2'b00, 1'(s), 7'(i), 32'd0, 0);

        do_req(1'b0, 2'b01, 1'b0, 7'h03, 32'd0, 0);
        do_req(1'b1, 2'b10, 1'b0, 7'h0A, 32'h12345678, 0);
        do_req(1'b0, 2'b11, 1'b0, 7'h00, 32'd0, 0);

        do_req(1'b0, 2'b10, 1'b0, 7'h08, 32'd0, 5);

        // Reset lands on the edge that would enter WRITE of a half store.
        @(negedge Clk);
        mem[3] = 32'h55667788; ref_mem[3] = 32'h55667788;
        ReqValid = 1'b1; ReqWrite = 1'b1; ReqSize = 2'b01; ReqSigned = 1'b0;
        ReqAddr = 7'h0E; ReqWData = 32'h0000CAFE; RespReady = 1'b1;
        @(posedge Clk); #1;
        ReqValid = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        chk_reset_outputs("midreset");
        chk("midreset_mem", mem[3], 32'h55667788);
        Rst_n = 1'b1;
        do_req(1'b0, 2'b01, 1'b0, 7'h0E, 32'd0, 0);

        for (int k = 0; k < 200; k++)
            do_req(1'($urandom), 2'($urandom), 1'($urandom), 7'($urandom), $urandom,
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);

        repeat (3) @(negedge Clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        chk("write_count", 32'(wr_cnt), 32'(exp_wr));
        for (int i = 0; i < 32; i++) chk($sformatf("mem_final_%0d", i), mem[i], ref_mem[i]);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
